// File: rtl/aes_inv_round_seq.sv
// Iterative inverse AES-128 round: AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes.
// Column-serial datapath with four inverse S-boxes and one InvMixColumns column unit.
module aes_inv_round_seq #(
    parameter int unsigned SKIP_MIX_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        SUB,
        DONE
    } state_t;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (r,c) of a column-major state; byte 0 sits in the top bits.
    function automatic logic [7:0] byte_at(
        input logic [127:0] s,
        input logic [1:0]   r,
        input logic [1:0]   c
    );
        return s[{~{c, r}, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[(3-i)*8 +: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] tmp_q, tmp_d;
    logic         skip_q, skip_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] state_out_q, state_out_d;

    logic [31:0]  mix_in;
    logic [31:0]  mix_out;
    logic [31:0]  sub_col;

    assign mix_in  = tmp_q[{~col_cnt_q, 5'b00000} +: 32];
    assign mix_out = skip_q ? mix_in : inv_mix_col(mix_in);

    // InvShiftRows folded into the read: row r of column c comes from column c-r.
    assign sub_col = {
        inv_sbox(byte_at(tmp_q, 2'd0, col_cnt_q)),
        inv_sbox(byte_at(tmp_q, 2'd1, col_cnt_q - 2'd1)),
        inv_sbox(byte_at(tmp_q, 2'd2, col_cnt_q - 2'd2)),
        inv_sbox(byte_at(tmp_q, 2'd3, col_cnt_q - 2'd3))
    };

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        tmp_d       = tmp_q;
        skip_d      = skip_q;
        out_valid_d = out_valid_q;
        state_out_d = state_out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tmp_d     = state_in ^ round_key;
                    skip_d    = (SKIP_MIX_EN != 0) && skip_mix;
                    col_cnt_d = 2'd0;
                    state_d   = MIX;
                end
            end
            MIX: begin
                tmp_d[{~col_cnt_q, 5'b00000} +: 32] = mix_out;
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    col_cnt_d = 2'd0;
                    state_d   = SUB;
                end
            end
            SUB: begin
                state_out_d[{~col_cnt_q, 5'b00000} +: 32] = sub_col;
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    col_cnt_d   = 2'd0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= 2'd0;
            tmp_q       <= '0;
            skip_q      <= 1'b0;
            out_valid_q <= 1'b0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            tmp_q       <= tmp_d;
            skip_q      <= skip_d;
            out_valid_q <= out_valid_d;
            state_out_q <= state_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Bench for aes_inv_round_seq: known-answer inverse rounds, stall, abort and
// back-to-back traffic, checked through a queue of expected results.
module tb_aes_inv_round_seq;

    localparam logic [127:0] P  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V1 = 128'h5f72641557f5bc92f7be3b291db9f91a;
    localparam logic [127:0] V2 = 128'h5f73661653f0ba95ffb7312211b4f715;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V3 = 128'h6353e08c0960e104cd70b751bacad0e7;

    typedef struct {
        logic [127:0] exp;
        bit           chk;
        logic [127:0] exp_ns;
        bit           chk_ns;
    } sb_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         ns_in_ready;
    logic         ns_out_valid;
    logic [127:0] ns_state_out;

    sb_t sbq[$];
    sb_t mon_e;
    int  n_vec  = 0;
    int  n_miss = 0;

    aes_inv_round_seq #(.SKIP_MIX_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .skip_mix  (skip_mix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    aes_inv_round_seq #(.SKIP_MIX_EN(0)) dut_ns (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ns_in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .skip_mix  (skip_mix),
        .out_valid (ns_out_valid),
        .out_ready (out_ready),
        .state_out (ns_state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: pop one expectation per completed output handshake.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_out got %h required none", state_out);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.chk) begin
                    n_vec++;
                    if (state_out !== mon_e.exp) begin
                        n_miss++;
                        $display("FAIL result got %h required %h", state_out, mon_e.exp);
                    end
                end
                if (mon_e.chk_ns) begin
                    n_vec++;
                    if (ns_out_valid !== 1'b1 || ns_state_out !== mon_e.exp_ns) begin
                        n_miss++;
                        $display("FAIL result_noskip got v=%b %h required v=1 %h",
                                 ns_out_valid, ns_state_out, mon_e.exp_ns);
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] s, input logic [127:0] k,
                        input logic sk, input sb_t e);
        int i;
        state_in  = s;
        round_key = k;
        skip_mix  = sk;
        in_valid  = 1'b1;
        i = 0;
        while (!in_ready && i < 40) begin
            @(negedge clk);
            i++;
        end
        n_vec++;
        if (!in_ready) begin
            n_miss++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            sbq.push_back(e);
            @(posedge clk);
            @(negedge clk);
            in_valid  = 1'b0;
            state_in  = rnd128();
            round_key = rnd128();
            skip_mix  = ~sk;
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sbq.size() != 0 && i < 60) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        n_vec++;
        if (sbq.size() != 0) begin
            n_miss++;
            $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || state_out !== '0 || in_ready !== 1'b1 ||
            ns_out_valid !== 1'b0 || ns_in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_state got v=%b out=%h rdy=%b required v=0 out=0 rdy=1",
                     out_valid, state_out, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL post_reset got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        sb_t e_full, e_skip;
        logic [127:0] k;
        int lat;
        e_full = '{exp: P, chk: 1'b1, exp_ns: P, chk_ns: 1'b1};
        e_skip = '{exp: P, chk: 1'b1, exp_ns: '0, chk_ns: 1'b0};
        out_ready = 1'b1;
        send(V1, '0, 1'b0, e_full);
        wait_out(lat);
        n_vec++;
        if (lat !== 8) begin
            n_miss++;
            $display("FAIL latency_v1 got %0d required 8", lat);
        end
        send(V2, K2, 1'b0, e_full);
        wait_out(lat);
        n_vec++;
        if (lat !== 8) begin
            n_miss++;
            $display("FAIL latency_v2 got %0d required 8", lat);
        end
        send(V3, '0, 1'b1, e_skip);
        wait_out(lat);
        n_vec++;
        if (lat !== 8) begin
            n_miss++;
            $display("FAIL latency_skip got %0d required 8", lat);
        end
        // Key whitening is linear, so any key paired with V^key must decode to P.
        for (int i = 0; i < 3; i++) begin
            k = rnd128();
            send(V1 ^ k, k, 1'b0, e_full);
            wait_out(lat);
            k = rnd128();
            send(V3 ^ k, k, 1'b1, e_skip);
            wait_out(lat);
        end
        drain();
    endtask

    task automatic test_hold();
        sb_t e;
        int lat;
        int seen;
        e = '{exp: P, chk: 1'b1, exp_ns: P, chk_ns: 1'b1};
        out_ready = 1'b0;
        send(V1, '0, 1'b0, e);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || state_out !== P || in_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL hold_%0d got v=%b out=%h rdy=%b required v=1 out=%h rdy=0",
                         i, out_valid, state_out, in_ready, P);
            end
            in_valid  = ~in_valid;
            state_in  = rnd128();
            round_key = rnd128();
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL hold_release got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_miss++;
            $display("FAIL hold_extra_results got %0d required 0", seen);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        sb_t e;
        int lat;
        int seen;
        e = '{exp: P, chk: 1'b1, exp_ns: P, chk_ns: 1'b1};
        out_ready = 1'b1;
        send(V2, K2, 1'b0, e);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || state_out !== '0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL abort got v=%b out=%h rdy=%b required v=0 out=0 rdy=1",
                     out_valid, state_out, in_ready);
        end
        rst = 1'b0;
        sbq.delete();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_miss++;
            $display("FAIL abort_partial got %0d required 0", seen);
        end
        send(V1, '0, 1'b0, e);
        wait_out(lat);
        n_vec++;
        if (lat !== 8) begin
            n_miss++;
            $display("FAIL latency_after_abort got %0d required 8", lat);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int cyc;
        int idx;
        logic [127:0] k;
        logic sk;
        sb_t e;
        out_ready = 1'b1;
        cyc = 0;
        idx = 0;
        k   = rnd128();
        sk  = 1'b0;
        state_in  = V1 ^ k;
        round_key = k;
        skip_mix  = sk;
        in_valid  = 1'b1;
        while (idx < 4 && cyc < 200) begin
            if (in_ready) begin
                e = '{exp: P, chk: 1'b1, exp_ns: P, chk_ns: !sk};
                sbq.push_back(e);
                acc.push_back(cyc);
                idx++;
                k  = rnd128();
                sk = idx[0];
            end
            @(negedge clk);
            cyc++;
            if (idx < 4) begin
                state_in  = (sk ? V3 : V1) ^ k;
                round_key = k;
                skip_mix  = sk;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (acc.size() != 4) begin
            n_miss++;
            $display("FAIL b2b_accepts got %0d required 4", acc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (acc[i] - acc[i-1] != 10) begin
                    n_miss++;
                    $display("FAIL b2b_interval_%0d got %0d required 10", i, acc[i] - acc[i-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_skip_disabled();
        sb_t e;
        int lat;
        e = '{exp: '0, chk: 1'b0, exp_ns: P, chk_ns: 1'b1};
        out_ready = 1'b1;
        send(V1, '0, 1'b1, e);
        wait_out(lat);
        n_vec++;
        if (lat !== 8) begin
            n_miss++;
            $display("FAIL latency_noskip got %0d required 8", lat);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        state_in  = '0;
        round_key = '0;
        skip_mix  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_skip_disabled();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
